// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA engine with a start/busy/done handshake.
// A working register is shifted by a small step per cycle until the captured
// shift amount is consumed, so no full barrel shifter is needed.
//
// Build option: define SHIFT_SEQ_FAST_EN to add a 4-bit step that is used while
// at least 4 bit positions remain. Results are identical in both builds; only
// the number of cycles spent in SHIFT changes.
module shift_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             operation,
    input  logic [DATA_WIDTH-1:0]  operand,
    input  logic [SHAMT_WIDTH-1:0] shiftAmount,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [SHAMT_WIDTH-1:0] STEP_ONE = SHAMT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [DATA_WIDTH-1:0]   work_q,      work_d;
    logic [SHAMT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [1:0]              op_q,        op_d;
    logic                    sign_q,      sign_d;
    logic [DATA_WIDTH-1:0]   result_q,    result_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    // Bit shifted in at the top for right shifts: the captured sign for SRA, else 0.
    logic fill_bit;
    assign fill_bit = (op_q == OP_SRA) & sign_q;

    // Single-bit shift networks built per bit position.
    logic [DATA_WIDTH-1:0] sll1;
    logic [DATA_WIDTH-1:0] srl1;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_step1
            if (gi == 0) begin : g_lsb
                assign sll1[gi] = 1'b0;
            end else begin : g_lsb_n
                assign sll1[gi] = work_q[gi-1];
            end
            if (gi == DATA_WIDTH - 1) begin : g_msb
                assign srl1[gi] = fill_bit;
            end else begin : g_msb_n
                assign srl1[gi] = work_q[gi+1];
            end
        end
    endgenerate

    // Step selected for this SHIFT cycle: size plus the left/right shifted values.
    logic [SHAMT_WIDTH-1:0] step_size;
    logic [DATA_WIDTH-1:0]  step_left;
    logic [DATA_WIDTH-1:0]  step_right;

`ifdef SHIFT_SEQ_FAST_EN
    localparam logic [SHAMT_WIDTH-1:0] STEP_FOUR = SHAMT_WIDTH'(4);

    logic [DATA_WIDTH-1:0] sll4;
    logic [DATA_WIDTH-1:0] srl4;
    logic                  use_four;

    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_step4
            if (gi < 4) begin : g_lo
                assign sll4[gi] = 1'b0;
            end else begin : g_lo_n
                assign sll4[gi] = work_q[gi-4];
            end
            if (gi >= DATA_WIDTH - 4) begin : g_hi
                assign srl4[gi] = fill_bit;
            end else begin : g_hi_n
                assign srl4[gi] = work_q[gi+4];
            end
        end
    endgenerate

    // The wide step is only taken when it cannot overrun the remaining count.
    assign use_four   = (remaining_q >= STEP_FOUR);
    assign step_size  = use_four ? STEP_FOUR : STEP_ONE;
    assign step_left  = use_four ? sll4 : sll1;
    assign step_right = use_four ? srl4 : srl1;
`else
    assign step_size  = STEP_ONE;
    assign step_left  = sll1;
    assign step_right = srl1;
`endif

    logic [SHAMT_WIDTH-1:0] remaining_step;
    assign remaining_step = remaining_q - step_size;

    // Next-state and next-output logic for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        sign_d      = sign_q;
        result_d    = result_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    work_d      = operand;
                    remaining_d = shiftAmount;
                    op_d        = operation;
                    sign_d      = operand[DATA_WIDTH-1];
                    busy_d      = 1'b1;
                    // Nothing to shift: finish immediately with the operand as is.
                    if ((shiftAmount == '0) || (operation == OP_RSV)) begin
                        state_d  = ST_DONE;
                        result_d = operand;
                        done_d   = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                busy_d      = 1'b1;
                work_d      = (op_q == OP_SLL) ? step_left : step_right;
                remaining_d = remaining_step;
                // Result is published only on the edge that enters DONE.
                if (remaining_step == '0) begin
                    state_d  = ST_DONE;
                    result_d = work_d;
                    done_d   = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            remaining_q <= '0;
            op_q        <= 2'b00;
            sign_q      <= 1'b0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: directed scenarios plus randomized operations
// checked against a reference model built from SV shift operators.
// Honours SHIFT_SEQ_FAST_EN for the expected latencies.
module tb_shift_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  operation;
    logic [31:0] operand;
    logic [4:0]  shiftAmount;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int compared   = 0;
    int mismatched = 0;
    int done_count = 0;

`ifdef SHIFT_SEQ_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    shift_sequencer #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .operation   (operation),
        .operand     (operand),
        .shiftAmount (shiftAmount),
        .result      (result),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count every done pulse, sampled away from the active edge.
    always @(negedge clock) begin
        if (done === 1'b1) done_count++;
    end

    // Reference result computed directly from the shift semantics.
    function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                 input logic [4:0] n);
        logic [31:0] r;
        case (op)
            2'b00:   r = a << n;
            2'b01:   r = a >> n;
            2'b10:   r = $signed(a) >>> n;
            default: r = a;
        endcase
        return r;
    endfunction

    // Number of shift cycles for a request.
    function automatic int model_steps(input logic [1:0] op, input logic [4:0] n);
        if (op == 2'b11) return 0;
        if (FAST) return (int'(n) / 4) + (int'(n) % 4);
        return int'(n);
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Issue one request from IDLE and check busy, latency, result and the cycle after done.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [4:0] n, input logic [31:0] exp_r, input int exp_c);
        int c;
        bit seen;
        operation   = op;
        operand     = a;
        shiftAmount = n;
        start       = 1'b1;
        next_cycle();
        start       = 1'b0;
        operation   = 2'($urandom);
        operand     = $urandom;
        shiftAmount = 5'($urandom);
        c = 1;
        seen = 1'b0;
        while (!seen && c <= 64) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                compared++;
                if (busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL %s busy cycle %0d: got %b want 1", name, c, busy);
                end
                next_cycle();
                c++;
            end
        end
        compared++;
        if (!seen || c != exp_c) begin
            mismatched++;
            $display("FAIL %s latency: got cycle %0d (seen=%0d) want cycle %0d", name, c, seen, exp_c);
        end
        compared++;
        if (result !== exp_r) begin
            mismatched++;
            $display("FAIL %s result: got %h want %h", name, result, exp_r);
        end
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL %s busy in done cycle: got %b want 1", name, busy);
        end
        next_cycle();
        compared++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_r) begin
            mismatched++;
            $display("FAIL %s after done: got done=%b busy=%b result=%h want 0 0 %h",
                     name, done, busy, result, exp_r);
        end
        $display("op %s: op=%0d a=%h n=%0d result=%h cycle=%0d", name, op, a, n, result, c);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        operation = 2'b00;
        operand = '0;
        shiftAmount = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            mismatched++;
            $display("FAIL reset state: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        next_cycle();
        $display("reset: busy=%b done=%b result=%h", busy, done, result);
    endtask

    task automatic test_directed();
        do_op("sll1x4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010, FAST ? 2 : 5);
        do_op("sra_msb31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, FAST ? 11 : 32);
        do_op("srl_msb31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, FAST ? 11 : 32);
        do_op("sra_pos", 2'b10, 32'h4000_0000, 5'd6, 32'h0100_0000, FAST ? 4 : 7);
    endtask

    task automatic test_zero_reserved();
        do_op("zero_amt", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
        do_op("reserved", 2'b11, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF, 1);
    endtask

    task automatic test_start_while_busy();
        int dc0;
        int done_c;
        logic [31:0] done_r;
        dc0 = done_count;
        done_c = -1;
        done_r = '0;
        operation = 2'b00;
        operand = 32'h0000_000F;
        shiftAmount = 5'd8;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (done === 1'b1) begin
                done_c = c;
                done_r = result;
            end
            if (c == 3) begin
                start = 1'b1;
                operation = 2'b01;
                operand = 32'hABCD_1234;
                shiftAmount = 5'd1;
            end else begin
                start = 1'b0;
            end
            next_cycle();
        end
        compared++;
        if (done_count - dc0 != 1) begin
            mismatched++;
            $display("FAIL busy_start done count: got %0d want 1", done_count - dc0);
        end
        compared++;
        if (done_r !== 32'h0000_0F00 || result !== 32'h0000_0F00) begin
            mismatched++;
            $display("FAIL busy_start result: got %h/%h want 00000f00", done_r, result);
        end
        compared++;
        if (done_c != (FAST ? 3 : 9) || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_start latency: got cycle %0d busy=%b want cycle %0d busy 0",
                     done_c, busy, FAST ? 3 : 9);
        end
        $display("busy_start: done_cycle=%0d result=%h", done_c, result);
    endtask

    task automatic test_reset_mid();
        int dc0;
        dc0 = done_count;
        operation = 2'b00;
        operand = 32'h0000_0001;
        shiftAmount = 5'd20;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 5; c++) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_mid state: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        for (int c = 0; c < 30; c++) next_cycle();
        compared++;
        if (done_count != dc0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid no done: got %0d dones busy=%b want 0 dones busy 0",
                     done_count - dc0, busy);
        end
        $display("reset_mid: busy=%b result=%h dones=%0d", busy, result, done_count - dc0);
        do_op("after_reset", 2'b01, 32'h0000_0100, 5'd8, 32'h0000_0001, FAST ? 3 : 9);
    endtask

    task automatic test_back_to_back();
        int da, db;
        logic exp_busy, exp_done;
        da = 1 + (FAST ? 3 : 3);
        db = da + 2 + (FAST ? 2 : 5);
        operation = 2'b10;
        operand = 32'h8000_0000;
        shiftAmount = 5'd3;
        start = 1'b1;
        next_cycle();
        operation = 2'b00;
        operand = 32'h1234_5678;
        shiftAmount = 5'd5;
        for (int c = 1; c <= db + 2; c++) begin
            exp_done = (c == da) || (c == db);
            exp_busy = (c <= da) || (c >= da + 2 && c <= db);
            compared++;
            if (done !== exp_done || busy !== exp_busy) begin
                mismatched++;
                $display("FAIL b2b cycle %0d: got done=%b busy=%b want %b %b",
                         c, done, busy, exp_done, exp_busy);
            end
            if (c >= da && c < db) begin
                compared++;
                if (result !== 32'hF000_0000) begin
                    mismatched++;
                    $display("FAIL b2b first result cycle %0d: got %h want f0000000", c, result);
                end
            end
            if (c == db) begin
                compared++;
                if (result !== 32'h468A_CF00) begin
                    mismatched++;
                    $display("FAIL b2b second result: got %h want 468acf00", result);
                end
                start = 1'b0;
            end
            next_cycle();
        end
        $display("b2b: first done cycle %0d second done cycle %0d result=%h", da, db, result);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  n;
        int gap;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a = $urandom;
            n = 5'($urandom);
            if (i % 8 == 0) n = 5'd0;
            do_op("random", op, a, n, model_result(op, a, n), 1 + model_steps(op, n));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        operation = 2'b00;
        operand = '0;
        shiftAmount = '0;
        #1;
        test_reset();
        test_directed();
        test_zero_reserved();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
